// File: rtl/pvs_pkg.sv
// Shared types and constants for the pacing event path: header codes, timestamped entry, arbiter state.
package pvs_pkg;

  localparam int HDR_W = 8;
  localparam int CTR_W = 32;

  localparam logic [HDR_W-1:0] IDLE_HDR  = 8'd0;
  localparam logic [HDR_W-1:0] HDR_RV    = 8'd4;
  localparam logic [HDR_W-1:0] HDR_RV_VP = 8'd6;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [HDR_W-1:0] hdr;
    logic [CTR_W-1:0] ts;
  } ev_entry_t;

  // Wrap-safe age compare: ts0 is older when (ts0 - ts1) is negative in CTR_W bits.
  function automatic logic ts0_older(input logic [CTR_W-1:0] ts0, input logic [CTR_W-1:0] ts1);
    logic [CTR_W-1:0] diff;
    diff = ts0 - ts1;
    return diff[CTR_W-1];
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Per-source circular buffer of timestamped events; head is always visible on dout_o.
// A push into a full buffer is discarded and flagged on drop_o for that cycle.
module event_fifo
  import pvs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  ev_entry_t din_i,
  output ev_entry_t dout_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ev_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // Fullness is judged before this edge's pop, so a simultaneous pop never makes room.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign drop_o  = push_i && full_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/event_header_arbiter.sv
// Merges sensed (src0) and pace (src1) events onto one header/counter strobe bus, oldest first,
// one-cycle pulses separated by GAP_CYC idle cycles; per-source FIFOs with sticky drop flags.
module event_header_arbiter
  import pvs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev0_valid,
  input  logic [HDR_W-1:0] ev0_header,
  input  logic             ev1_valid,
  input  logic [HDR_W-1:0] ev1_header,
  input  logic             clear_ovf,
  output logic [HDR_W-1:0] header,
  output logic [CTR_W-1:0] counter,
  output logic             ev0_full,
  output logic             ev1_full,
  output logic             ovf0,
  output logic             ovf1
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [CTR_W-1:0] ts_q;
  arb_state_e       state_q;
  logic [GW-1:0]    gap_q;
  logic             rr_q;
  logic [HDR_W-1:0] header_q;
  logic [CTR_W-1:0] counter_q;
  logic             ovf0_q;
  logic             ovf1_q;

  ev_entry_t din0, din1, head0, head1, win_d;
  logic      push0, push1, pop0, pop1;
  logic      empty0, empty1, drop0, drop1;
  logic      grant, sel1_d;

  assign push0 = ev0_valid && (ev0_header != IDLE_HDR);
  assign push1 = ev1_valid && (ev1_header != IDLE_HDR);
  assign din0  = '{hdr: ev0_header, ts: ts_q};
  assign din1  = '{hdr: ev1_header, ts: ts_q};

  event_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk    (clk),
    .rst    (rst),
    .push_i (push0),
    .pop_i  (pop0),
    .din_i  (din0),
    .dout_o (head0),
    .full_o (ev0_full),
    .empty_o(empty0),
    .drop_o (drop0)
  );

  event_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk    (clk),
    .rst    (rst),
    .push_i (push1),
    .pop_i  (pop1),
    .din_i  (din1),
    .dout_o (head1),
    .full_o (ev1_full),
    .empty_o(empty1),
    .drop_o (drop1)
  );

  // rr_q==1 means src1 won last; on a timestamp tie the other source goes next.
  always_comb begin
    sel1_d = 1'b0;
    if (empty0) begin
      sel1_d = 1'b1;
    end else if (!empty1) begin
      if (head0.ts == head1.ts) begin
        sel1_d = !rr_q;
      end else begin
        sel1_d = !ts0_older(head0.ts, head1.ts);
      end
    end
  end

  assign grant = (state_q == IDLE) && (!empty0 || !empty1);
  assign pop0  = grant && !sel1_d;
  assign pop1  = grant && sel1_d;
  assign win_d = sel1_d ? head1 : head0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      rr_q      <= 1'b1;
      header_q  <= IDLE_HDR;
      counter_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            header_q  <= win_d.hdr;
            counter_q <= win_d.ts;
            rr_q      <= sel1_d;
            gap_q     <= GW'(GAP_CYC - 1);
            state_q   <= GAP;
          end else begin
            header_q <= IDLE_HDR;
          end
        end
        GAP: begin
          header_q <= IDLE_HDR;
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: begin
          header_q <= IDLE_HDR;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q   <= '0;
      ovf0_q <= 1'b0;
      ovf1_q <= 1'b0;
    end else begin
      ts_q <= ts_q + CTR_W'(1);
      if (drop0) begin
        ovf0_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf0_q <= 1'b0;
      end
      if (drop1) begin
        ovf1_q <= 1'b1;
      end else if (clear_ovf) begin
        ovf1_q <= 1'b0;
      end
    end
  end

  assign header  = header_q;
  assign counter = counter_q;
  assign ovf0    = ovf0_q;
  assign ovf1    = ovf1_q;

endmodule

// File: tb/tb_event_header_arbiter.sv
// Directed bench: per-cycle vector table (row index == captured timestamp) plus wrap/reset sequences.
module tb_event_header_arbiter;
  import pvs_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             ev0_valid, ev1_valid, clear_ovf;
  logic [HDR_W-1:0] ev0_header, ev1_header;
  logic [HDR_W-1:0] header;
  logic [CTR_W-1:0] counter;
  logic             ev0_full, ev1_full, ovf0, ovf1;

  int total = 0;
  int bad   = 0;

  event_header_arbiter #(.DEPTH(4), .GAP_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ev0_valid (ev0_valid),
    .ev0_header(ev0_header),
    .ev1_valid (ev1_valid),
    .ev1_header(ev1_header),
    .clear_ovf (clear_ovf),
    .header    (header),
    .counter   (counter),
    .ev0_full  (ev0_full),
    .ev1_full  (ev1_full),
    .ovf0      (ovf0),
    .ovf1      (ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] h0;
    logic       v1;
    logic [7:0] h1;
    logic       clr;
    logic       chk;
    logic [7:0] eh;
    logic [31:0] ec;
    logic       f0, f1, o0, o1;
  } vec_t;

  localparam int NROWS = 70;
  vec_t tbl [NROWS];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic stim(input int i, input logic v0, input logic [7:0] h0,
                      input logic v1, input logic [7:0] h1, input logic clr);
    tbl[i].v0  = v0;
    tbl[i].h0  = h0;
    tbl[i].v1  = v1;
    tbl[i].h1  = h1;
    tbl[i].clr = clr;
  endtask

  task automatic exp_row(input int i, input logic [7:0] eh, input logic [31:0] ec,
                         input logic f0, input logic f1, input logic o0, input logic o1);
    tbl[i].chk = 1'b1;
    tbl[i].eh  = eh;
    tbl[i].ec  = ec;
    tbl[i].f0  = f0;
    tbl[i].f1  = f1;
    tbl[i].o0  = o0;
    tbl[i].o1  = o1;
  endtask

  task automatic drive(input logic v0, input logic [7:0] h0, input logic v1,
                       input logic [7:0] h1, input logic clr);
    ev0_valid  = v0;
    ev0_header = h0;
    ev1_valid  = v1;
    ev1_header = h1;
    clear_ovf  = clr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_pulse(input string nm, input logic [7:0] eh, input logic [31:0] ec);
    check({nm, " hdr"}, 64'(header), 64'(eh));
    check({nm, " ctr"}, 64'(counter), 64'(ec));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'd0, 0, 8'd0, 0);
    for (int i = 0; i < NROWS; i++) tbl[i] = '{default: '0};

    // single event, ignored IDLE_HDR capture, lone pace event (rr_last -> src1)
    stim(10, 1, HDR_RV, 0, 8'd0, 0);
    stim(14, 1, IDLE_HDR, 0, 8'd0, 0);
    stim(15, 0, 8'd0, 1, HDR_RV_VP, 0);
    // simultaneous arrival
    stim(20, 1, HDR_RV, 1, HDR_RV_VP, 0);
    // age ordering while busy
    stim(29, 1, 8'd5, 0, 8'd0, 0);
    stim(30, 0, 8'd0, 1, HDR_RV_VP, 0);
    stim(31, 1, HDR_RV, 0, 8'd0, 0);
    // overflow flood; clear at 45 collides with a src1 drop
    for (int k = 0; k < 6; k++) stim(40 + k, 1, 8'(10 + k), 1, 8'(20 + k), (k == 5));
    stim(51, 0, 8'd0, 0, 8'd0, 1);

    exp_row(0,  8'd0, 32'd0,  0, 0, 0, 0);
    exp_row(9,  8'd0, 32'd0,  0, 0, 0, 0);
    exp_row(10, 8'd0, 32'd0,  0, 0, 0, 0);
    exp_row(11, 8'd4, 32'd10, 0, 0, 0, 0);
    exp_row(12, 8'd0, 32'd10, 0, 0, 0, 0);
    exp_row(13, 8'd0, 32'd10, 0, 0, 0, 0);
    exp_row(15, 8'd0, 32'd10, 0, 0, 0, 0);
    exp_row(16, 8'd6, 32'd15, 0, 0, 0, 0);
    exp_row(19, 8'd0, 32'd15, 0, 0, 0, 0);
    exp_row(20, 8'd0, 32'd15, 0, 0, 0, 0);
    exp_row(21, 8'd4, 32'd20, 0, 0, 0, 0);
    exp_row(22, 8'd0, 32'd20, 0, 0, 0, 0);
    exp_row(23, 8'd0, 32'd20, 0, 0, 0, 0);
    exp_row(24, 8'd6, 32'd20, 0, 0, 0, 0);
    exp_row(25, 8'd0, 32'd20, 0, 0, 0, 0);
    exp_row(30, 8'd5, 32'd29, 0, 0, 0, 0);
    exp_row(31, 8'd0, 32'd29, 0, 0, 0, 0);
    exp_row(32, 8'd0, 32'd29, 0, 0, 0, 0);
    exp_row(33, 8'd6, 32'd30, 0, 0, 0, 0);
    exp_row(34, 8'd0, 32'd30, 0, 0, 0, 0);
    exp_row(35, 8'd0, 32'd30, 0, 0, 0, 0);
    exp_row(36, 8'd4, 32'd31, 0, 0, 0, 0);
    exp_row(37, 8'd0, 32'd31, 0, 0, 0, 0);
    exp_row(40, 8'd0,  32'd31, 0, 0, 0, 0);
    exp_row(41, 8'd20, 32'd40, 0, 0, 0, 0);
    exp_row(42, 8'd0,  32'd40, 0, 0, 0, 0);
    exp_row(43, 8'd0,  32'd40, 1, 0, 0, 0);
    exp_row(44, 8'd10, 32'd40, 0, 1, 1, 0);
    exp_row(45, 8'd0,  32'd40, 1, 1, 0, 1);
    exp_row(46, 8'd0,  32'd40, 1, 1, 0, 1);
    exp_row(47, 8'd21, 32'd41, 1, 0, 0, 1);
    exp_row(50, 8'd11, 32'd41, 0, 0, 0, 1);
    exp_row(51, 8'd0,  32'd41, 0, 0, 0, 0);
    exp_row(53, 8'd22, 32'd42, 0, 0, 0, 0);
    exp_row(56, 8'd12, 32'd42, 0, 0, 0, 0);
    exp_row(59, 8'd23, 32'd43, 0, 0, 0, 0);
    exp_row(62, 8'd13, 32'd43, 0, 0, 0, 0);
    exp_row(65, 8'd24, 32'd44, 0, 0, 0, 0);
    exp_row(68, 8'd15, 32'd45, 0, 0, 0, 0);
    exp_row(69, 8'd0,  32'd45, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("reset hdr",  64'(header),   64'(IDLE_HDR));
    check("reset ctr",  64'(counter),  64'd0);
    check("reset full0", 64'(ev0_full), 64'd0);
    check("reset full1", 64'(ev1_full), 64'd0);
    check("reset ovf0", 64'(ovf0),     64'd0);
    check("reset ovf1", 64'(ovf1),     64'd0);

    rst = 1'b0;
    for (int i = 0; i < NROWS; i++) begin
      drive(tbl[i].v0, tbl[i].h0, tbl[i].v1, tbl[i].h1, tbl[i].clr);
      step();
      if (tbl[i].chk) begin
        check($sformatf("row%0d hdr", i),   64'(header),   64'(tbl[i].eh));
        check($sformatf("row%0d ctr", i),   64'(counter),  64'(tbl[i].ec));
        check($sformatf("row%0d full0", i), 64'(ev0_full), 64'(tbl[i].f0));
        check($sformatf("row%0d full1", i), 64'(ev1_full), 64'(tbl[i].f1));
        check($sformatf("row%0d ovf0", i),  64'(ovf0),     64'(tbl[i].o0));
        check($sformatf("row%0d ovf1", i),  64'(ovf1),     64'(tbl[i].o1));
      end
    end
    drive(0, 8'd0, 0, 8'd0, 0);

    // Timestamp wrap: fresh reset, then jump ts to 0xFFFFFFFE.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force dut.ts_q = 32'hFFFF_FFFE;
    #1;
    release dut.ts_q;
    drive(1, 8'd9, 1, HDR_RV_VP, 0);
    step();
    drive(0, 8'd0, 0, 8'd0, 0);
    check("wrap push hdr", 64'(header), 64'd0);
    step();
    check_pulse("wrap tie", 8'd9, 32'hFFFF_FFFE);
    step();
    check("wrap gap hdr", 64'(header), 64'd0);
    drive(1, HDR_RV, 0, 8'd0, 0);
    step();
    drive(0, 8'd0, 0, 8'd0, 0);
    check("wrap gap2 hdr", 64'(header), 64'd0);
    step();
    check_pulse("wrap src1 first", HDR_RV_VP, 32'hFFFF_FFFE);
    step();
    step();
    check("wrap idle hdr", 64'(header), 64'd0);
    step();
    check_pulse("wrap src0 second", HDR_RV, 32'd1);

    // Reset mid-gap with three entries pending.
    step();
    step();
    drive(1, 8'h11, 1, 8'h22, 0);
    step();
    drive(1, 8'h33, 0, 8'd0, 0);
    step();
    check_pulse("t6 pulse", 8'h22, 32'd8);
    drive(0, 8'd0, 1, 8'h44, 0);
    step();
    drive(0, 8'd0, 0, 8'd0, 0);
    check_pulse("t6 gap", 8'd0, 32'd8);
    #2;
    rst = 1'b1;
    #1;
    check("t6 async hdr", 64'(header),  64'd0);
    check("t6 async ctr", 64'(counter), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("t6 quiet%0d", k), 64'(header), 64'd0);
    end
    drive(0, 8'd0, 1, 8'h55, 0);
    step();
    drive(0, 8'd0, 0, 8'd0, 0);
    check("t6 new push hdr", 64'(header), 64'd0);
    step();
    check_pulse("t6 new pulse", 8'h55, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
